sd_cmd_framer: RTL and testbench

Controller that sequences a serial CRC7 engine (polynomial x^7+x^3+1) to build and transmit 48-bit SD-style command frames.
- Accepts one command (6-bit index, 32-bit argument) over a valid/ready handshake.
- Shifts the 40 header/payload bits out MSB-first while feeding them to the CRC7 shift register.
- Appends the 7 CRC bits and an end bit, then enforces an idle gap before accepting the next command.
- Sits between the command-issue logic and the CMD pad driver.

---
 rtl/sd_cmd_framer.sv | 178 +++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer
//   Builds and transmits one 48-bit SD-style command frame per accepted
//   command. The frame is: start(0), transmission(1), 6-bit index,
//   32-bit argument, CRC7 (x^7+x^3+1), end(1), sent MSB first.
//   After each frame the line is released for IDLE_GAP bit strobes
//   before the next command is accepted.
//
//   Optional feature macro: SD_CMD_CRC_ERR_INJ_EN
//     When defined, adds input err_inj (sampled on acceptance). If it was
//     set, the last CRC bit on the line is inverted. crc_out is unaffected.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   bit_en     bit-rate strobe; the frame advances only when high
//   cmd_valid  command request
//   cmd_ready  high in IDLE; command taken on cmd_valid & cmd_ready
//   cmd_index  6-bit command index, sampled on acceptance
//   cmd_arg    32-bit argument, sampled on acceptance
//   err_inj    (optional) corrupt last CRC bit of this frame
//   cmd_out    serial line data
//   cmd_oe     line drive enable
//   busy       high in any state except IDLE
//   done       one-cycle pulse after the end bit completes
//   crc_out    CRC7 of the most recently completed frame
module sd_cmd_framer #(
    parameter int unsigned IDLE_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
`ifdef SD_CMD_CRC_ERR_INJ_EN
    input  logic        err_inj,
`endif
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done,
    output logic [6:0]  crc_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CRC,
        S_END,
        S_GAP
    } state_t;

    localparam logic [7:0] HDR_LAST = 8'd39;
    localparam logic [7:0] CRC_LAST = 8'd6;
    localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);

    state_t      state, state_nxt;
    logic [39:0] hdr;
    logic [6:0]  crc;
    logic [6:0]  crc_upd;
    logic [7:0]  cnt;
    logic        cnt_last;
    logic        crc_g;
    logic        accept;
`ifdef SD_CMD_CRC_ERR_INJ_EN
    logic        err_q;
`endif

    assign accept = cmd_valid & cmd_ready;

    // Serial CRC7 step with the bit currently on the line.
    assign crc_g   = hdr[39] ^ crc[6];
    assign crc_upd = {crc[5], crc[4], crc[3], crc[2] ^ crc_g, crc[1], crc[0], crc_g};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        cmd_out   = 1'b1;
        cmd_oe    = 1'b0;
        busy      = 1'b1;
        cnt_last  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = S_HDR;
            end
            S_HDR: begin
                cmd_out  = hdr[39];
                cmd_oe   = 1'b1;
                cnt_last = (cnt == HDR_LAST);
                if (bit_en && cnt_last) state_nxt = S_CRC;
            end
            S_CRC: begin
                cnt_last = (cnt == CRC_LAST);
`ifdef SD_CMD_CRC_ERR_INJ_EN
                cmd_out  = crc[6] ^ (err_q & cnt_last);
`else
                cmd_out  = crc[6];
`endif
                cmd_oe   = 1'b1;
                if (bit_en && cnt_last) state_nxt = S_END;
            end
            S_END: begin
                cmd_oe = 1'b1;
                if (bit_en) state_nxt = S_GAP;
            end
            S_GAP: begin
                cnt_last = (cnt == GAP_LAST);
                if (bit_en && cnt_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr     <= '0;
            crc     <= '0;
            cnt     <= '0;
            crc_out <= '0;
            done    <= 1'b0;
`ifdef SD_CMD_CRC_ERR_INJ_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        hdr   <= {2'b01, cmd_index, cmd_arg};
                        crc   <= '0;
                        cnt   <= '0;
`ifdef SD_CMD_CRC_ERR_INJ_EN
                        err_q <= err_inj;
`endif
                    end
                end
                S_HDR: begin
                    if (bit_en) begin
                        crc <= crc_upd;
                        hdr <= {hdr[38:0], 1'b0};
                        if (cnt_last) begin
                            cnt     <= '0;
                            // Reported CRC includes the 40th header bit.
                            crc_out <= crc_upd;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (bit_en) begin
                        crc <= {crc[5:0], 1'b0};
                        cnt <= cnt_last ? 8'd0 : cnt + 8'd1;
                    end
                end
                S_END: begin
                    if (bit_en) begin
                        done <= 1'b1;
                        cnt  <= '0;
                    end
                end
                S_GAP: begin
                    if (bit_en) cnt <= cnt_last ? 8'd0 : cnt + 8'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb_sd_cmd_framer
//   Directed bench for sd_cmd_framer with IDLE_GAP=8. Frames are captured
//   off the serial line and compared with hand-computed 48-bit patterns.
module tb_sd_cmd_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        err_inj;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    logic [6:0]  crc_out;

    int checks   = 0;
    int failures = 0;

    sd_cmd_framer #(.IDLE_GAP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
`ifdef SD_CMD_CRC_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe),
        .busy      (busy),
        .done      (done),
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle k (k>=1) is the k-th cycle after the acceptance edge. bit_en is
    // high in cycles where k%p==0, so each bit is held p cycles. If hold is
    // set, cmd_valid stays high with CMD8 loaded so the next command is
    // taken on the edge that ends cycle 56p+1.
    task automatic run_frame(input string tag, input int p, input bit handshake,
                             input bit hold, input logic [5:0] idx, input logic [31:0] arg,
                             input bit inj, input logic [47:0] exp_frame,
                             input logic [6:0] exp_crc);
        logic [47:0] cap;
        logic        cur;
        bit          hold_ok;
        int          n;
        int          b;
        cap     = '0;
        cur     = 1'b0;
        hold_ok = 1'b1;
        if (handshake) begin
            @(negedge clk);
            n = 0;
            while (!cmd_ready && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_wait_ready"}, {63'd0, cmd_ready}, 64'd1);
            cmd_valid = 1'b1;
            cmd_index = idx;
            cmd_arg   = arg;
            err_inj   = inj;
            bit_en    = 1'b1;
        end
        @(posedge clk);
        for (int k = 1; k <= 56 * p + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    cmd_index = 6'h08;
                    cmd_arg   = 32'h0000_01AA;
                end else begin
                    cmd_valid = 1'b0;
                end
                chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
                chk({tag, "_ready_low"}, {63'd0, cmd_ready}, 64'd0);
            end
            bit_en = ((k % p) == 0);
            if (k <= 48 * p) begin
                b = (k - 1) / p;
                if (((k - 1) % p) == 0) begin
                    cap[47 - b] = cmd_out;
                    cur         = cmd_out;
                end else if (cmd_out !== cur) begin
                    hold_ok = 1'b0;
                end
                if (cmd_oe !== 1'b1) hold_ok = 1'b0;
            end
            if (k == 48 * p)     chk({tag, "_done_early"}, {63'd0, done}, 64'd0);
            if (k == 48 * p + 1) begin
                chk({tag, "_done"}, {63'd0, done}, 64'd1);
                chk({tag, "_crc_out"}, {57'd0, crc_out}, {57'd0, exp_crc});
                chk({tag, "_gap_oe"}, {63'd0, cmd_oe}, 64'd0);
            end
            if (k == 48 * p + 2) chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
            if (k == 56 * p)     chk({tag, "_gap_ready"}, {63'd0, cmd_ready}, 64'd0);
            if (k == 56 * p + 1) chk({tag, "_ready_back"}, {63'd0, cmd_ready}, 64'd1);
        end
        chk({tag, "_frame"}, {16'd0, cap}, {16'd0, exp_frame});
        chk({tag, "_bit_hold"}, {63'd0, hold_ok}, 64'd1);
    endtask

    initial begin
        bit done_seen;
        rst       = 1'b1;
        bit_en    = 1'b0;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        err_inj   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out",   {63'd0, cmd_out},   64'd1);
        chk("rst_oe",    {63'd0, cmd_oe},    64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_done",  {63'd0, done},      64'd0);
        chk("rst_crc",   {57'd0, crc_out},   64'd0);
        rst = 1'b0;

        run_frame("cmd0", 1, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 1'b0,
                  48'h40_0000_0000_95, 7'h4A);
        run_frame("cmd8", 1, 1'b1, 1'b0, 6'h08, 32'h0000_01AA, 1'b0,
                  48'h48_0000_01AA_87, 7'h43);

        // Reset partway through the header.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_index = 6'h00;
        cmd_arg   = 32'h0;
        bit_en    = 1'b1;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_oe",    {63'd0, cmd_oe},    64'd0);
        chk("mid_rst_out",   {63'd0, cmd_out},   64'd1);
        chk("mid_rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("mid_rst_busy",  {63'd0, busy},      64'd0);
        chk("mid_rst_crc",   {57'd0, crc_out},   64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk("mid_rst_no_done", {63'd0, done_seen}, 64'd0);
        chk("mid_rst_idle",    {63'd0, cmd_ready}, 64'd1);

        run_frame("cmd0_div4", 4, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 1'b0,
                  48'h40_0000_0000_95, 7'h4A);

        // cmd_valid held through the frame; CMD8 must wait for the gap.
        run_frame("hold_a", 1, 1'b1, 1'b1, 6'h00, 32'h0000_0000, 1'b0,
                  48'h40_0000_0000_95, 7'h4A);
        run_frame("hold_b", 1, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 1'b0,
                  48'h48_0000_01AA_87, 7'h43);

`ifdef SD_CMD_CRC_ERR_INJ_EN
        run_frame("inj", 1, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 1'b1,
                  48'h40_0000_0000_97, 7'h4A);
        run_frame("inj_clear", 1, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 1'b0,
                  48'h40_0000_0000_95, 7'h4A);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
